// File: rtl/sn_pkg.sv
// Shared constants and types for the SN76489 attenuator scheduler.
// Holds the bus-byte field positions and the scheduler state encoding.
package sn_pkg;

    localparam logic [3:0] ATT_SILENT = 4'hF;

    localparam int unsigned LATCH_BIT = 7;
    localparam int unsigned CH_MSB    = 6;
    localparam int unsigned CH_LSB    = 5;
    localparam int unsigned TYPE_BIT  = 4;

    localparam logic TYPE_ATT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/att_scheduler_if.sv
// Link to the shared external attenuator: the scheduler (master) drives the
// sound bit and attenuation select, and the attenuator (slave) returns the level.
interface att_scheduler_if;

    logic       att_snd_in;
    logic [3:0] att_sel;
    logic [5:0] att_level;

    modport master (
        output att_snd_in,
        output att_sel,
        input  att_level
    );

    modport slave (
        input  att_snd_in,
        input  att_sel,
        output att_level
    );

endinterface

// File: rtl/sn_att_regs.sv
// SN76489 bus-byte decoder and per-channel attenuation register file.
// Latch bytes pick channel/type; data bytes only update when the latched type is attenuation.
module sn_att_regs
    import sn_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic [NUM_CH-1:0][3:0] att_reg
);

    logic [1:0]             latch_ch_q, latch_ch_d;
    logic                   latch_type_q, latch_type_d;
    logic [NUM_CH-1:0][3:0] att_q, att_d;
    logic [1:0]             tgt_ch;
    logic                   upd;

    always_comb begin
        latch_ch_d   = latch_ch_q;
        latch_type_d = latch_type_q;
        att_d        = att_q;
        tgt_ch       = latch_ch_q;
        upd          = 1'b0;
        if (wr_en) begin
            if (wr_data[LATCH_BIT]) begin
                latch_ch_d   = wr_data[CH_MSB:CH_LSB];
                latch_type_d = wr_data[TYPE_BIT];
                tgt_ch       = wr_data[CH_MSB:CH_LSB];
                upd          = (wr_data[TYPE_BIT] == TYPE_ATT);
            end else begin
                upd = (latch_type_q == TYPE_ATT);
            end
        end
        // Channels beyond NUM_CH never match, so their updates fall away.
        for (int i = 0; i < NUM_CH; i++) begin
            if (upd && (tgt_ch == 2'(i))) begin
                att_d[i] = wr_data[3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latch_ch_q   <= 2'd0;
            latch_type_q <= 1'b0;
            att_q        <= {NUM_CH{ATT_SILENT}};
        end else begin
            latch_ch_q   <= latch_ch_d;
            latch_type_q <= latch_type_d;
            att_q        <= att_d;
        end
    end

    assign att_reg = att_q;

endmodule

// File: rtl/att_scheduler.sv
// Time-multiplexes one shared attenuator over the SN76489 channels and mixes the levels.
// Optional macro ATT_OVERRUN_EN adds a sticky overrun flag for ticks dropped while busy.
module att_scheduler
    import sn_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int MIX_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               frame_start,
    input  logic [NUM_CH-1:0]  ch_snd,
    att_scheduler_if.master    att,
    output logic [MIX_W-1:0]   mix_out,
    output logic               mix_valid,
    output logic               busy,
    output state_t             dbg_state
`ifdef ATT_OVERRUN_EN
    ,
    output logic               overrun
`endif
);

    localparam int          ACC_W   = 6 + $clog2(NUM_CH);
    localparam logic [31:0] MIX_MAX = (32'd1 << MIX_W) - 32'd1;

    logic [NUM_CH-1:0][3:0] att_reg;

    sn_att_regs #(.NUM_CH(NUM_CH)) u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .att_reg (att_reg)
    );

    state_t                 state_q, state_d;
    logic [1:0]             slot_q, slot_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [NUM_CH-1:0]      snap_snd_q, snap_snd_d;
    logic [NUM_CH-1:0][3:0] snap_att_q, snap_att_d;
    logic [MIX_W-1:0]       mix_out_q, mix_out_d;
    logic                   mix_valid_q, mix_valid_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic [31:0]            acc_wide;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        acc_d       = acc_q;
        snap_snd_d  = snap_snd_q;
        snap_att_d  = snap_att_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = overrun_q;
        acc_wide    = 32'd0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    snap_snd_d = ch_snd;
                    snap_att_d = att_reg;
                    acc_d      = '0;
                    slot_d     = 2'd0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + ACC_W'(att.att_level);
                // The mix is registered on the last slot so it is valid during DONE.
                if (slot_q == 2'(NUM_CH - 1)) begin
                    acc_wide    = 32'(acc_d);
                    mix_out_d   = (acc_wide > MIX_MAX) ? MIX_W'(MIX_MAX) : MIX_W'(acc_wide);
                    mix_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (frame_start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
        busy_d = (state_d == RUN) || (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= 2'd0;
            acc_q       <= '0;
            snap_snd_q  <= '0;
            snap_att_q  <= {NUM_CH{ATT_SILENT}};
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            acc_q       <= acc_d;
            snap_snd_q  <= snap_snd_d;
            snap_att_q  <= snap_att_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign att.att_snd_in = (state_q == RUN) ? snap_snd_q[slot_q] : 1'b0;
    assign att.att_sel    = (state_q == RUN) ? snap_att_q[slot_q] : ATT_SILENT;
    assign mix_out        = mix_out_q;
    assign mix_valid      = mix_valid_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;

`ifdef ATT_OVERRUN_EN
    assign overrun = overrun_q;
`else
    logic unused_overrun;
    assign unused_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_att_scheduler.sv
// Directed bench for att_scheduler: a default (MIX_W=8) and a narrow (MIX_W=7) instance
// share stimulus; each is served by a 2 dB-step attenuator model.
module tb_att_scheduler;
    import sn_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       frame_start = 1'b0;
    logic [3:0] ch_snd = 4'd0;

    logic [7:0] mix_out8;
    logic [6:0] mix_out7;
    logic       mix_valid8, mix_valid7, busy8, busy7;
    state_t     dbg8, dbg7;
`ifdef ATT_OVERRUN_EN
    logic       overrun8, overrun7;
`endif

    int checks = 0;
    int failures = 0;

    logic [5:0] lvl_tab [16];

    att_scheduler_if if8();
    att_scheduler_if if7();

    assign if8.att_level = if8.att_snd_in ? lvl_tab[if8.att_sel] : 6'd0;
    assign if7.att_level = if7.att_snd_in ? lvl_tab[if7.att_sel] : 6'd0;

    att_scheduler #(.NUM_CH(4), .MIX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .frame_start(frame_start), .ch_snd(ch_snd), .att(if8),
        .mix_out(mix_out8), .mix_valid(mix_valid8), .busy(busy8), .dbg_state(dbg8)
`ifdef ATT_OVERRUN_EN
        , .overrun(overrun8)
`endif
    );

    att_scheduler #(.NUM_CH(4), .MIX_W(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .frame_start(frame_start), .ch_snd(ch_snd), .att(if7),
        .mix_out(mix_out7), .mix_valid(mix_valid7), .busy(busy7), .dbg_state(dbg7)
`ifdef ATT_OVERRUN_EN
        , .overrun(overrun7)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Drives a tick in cycle T and samples cycles T+1..T+7 mid-cycle.
    task automatic run_frame(input logic [3:0] snd, input logic [7:0] e8, input logic [6:0] e7,
                             input int extra_at, input int wr_at, input logic [7:0] wr_b,
                             input int rst_at);
        @(negedge clk);
        frame_start = 1'b1;
        ch_snd = snd;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            frame_start = 1'b0;
            wr_en = 1'b0;
            if (rst_at == 0 || k <= rst_at) begin
                chk("busy", int'(busy8), int'(k <= 5));
                chk("mix_valid", int'(mix_valid8), int'(k == 5));
                if (k == 5) begin
                    chk("mix_out", int'(mix_out8), int'(e8));
                    chk("mix_out_w7", int'(mix_out7), int'(e7));
                    chk("mix_valid_w7", int'(mix_valid7), 1);
                end
                if (k == 6) begin
                    chk("att_sel_idle", int'(if8.att_sel), 15);
                    chk("att_snd_idle", int'(if8.att_snd_in), 0);
                    chk("state_idle", int'(dbg8), int'(IDLE));
                end
            end else begin
                chk("busy_after_rst", int'(busy8), 0);
                chk("mix_valid_after_rst", int'(mix_valid8), 0);
                if (k == 7) begin
                    chk("mix_out_after_rst", int'(mix_out8), 0);
                    chk("mix_out_w7_after_rst", int'(mix_out7), 0);
                end
            end
            if (k == 1) ch_snd = ~snd;
            if (k == extra_at) frame_start = 1'b1;
            if (k == wr_at) begin
                wr_en = 1'b1;
                wr_data = wr_b;
            end
            if (k == rst_at) rst_n = 1'b0;
            if (rst_at != 0 && k == rst_at + 1) rst_n = 1'b1;
        end
    endtask

    typedef struct {
        bit         rst;
        int         nw;
        logic [7:0] w0, w1, w2, w3;
        logic [3:0] snd;
        logic [7:0] e8;
        logic [6:0] e7;
    } vec_t;

    vec_t vecs [8];

    initial begin
        lvl_tab[0]  = 6'd63; lvl_tab[1]  = 6'd50; lvl_tab[2]  = 6'd40; lvl_tab[3]  = 6'd32;
        lvl_tab[4]  = 6'd25; lvl_tab[5]  = 6'd20; lvl_tab[6]  = 6'd16; lvl_tab[7]  = 6'd13;
        lvl_tab[8]  = 6'd10; lvl_tab[9]  = 6'd8;  lvl_tab[10] = 6'd6;  lvl_tab[11] = 6'd5;
        lvl_tab[12] = 6'd4;  lvl_tab[13] = 6'd3;  lvl_tab[14] = 6'd2;  lvl_tab[15] = 6'd0;

        vecs[0] = '{1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1111, 8'd0,   7'd0};
        vecs[1] = '{1'b0, 2, 8'h90, 8'hB2, 8'h00, 8'h00, 4'b1111, 8'd103, 7'd103};
        vecs[2] = '{1'b0, 2, 8'hD0, 8'h05, 8'h00, 8'h00, 4'b0100, 8'd20,  7'd20};
        vecs[3] = '{1'b0, 2, 8'hC0, 8'h05, 8'h00, 8'h00, 4'b0100, 8'd20,  7'd20};
        vecs[4] = '{1'b0, 4, 8'h90, 8'hB0, 8'hD0, 8'hF0, 4'b1111, 8'd252, 7'd127};
        vecs[5] = '{1'b0, 2, 8'hB0, 8'h03, 8'h00, 8'h00, 4'b0011, 8'd95,  7'd95};
        vecs[6] = '{1'b0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'd0,   7'd0};
        vecs[7] = '{1'b0, 1, 8'hF7, 8'h00, 8'h00, 8'h00, 4'b1001, 8'd76,  7'd76};

        do_reset();
        @(negedge clk);
        chk("rst_mix_out", int'(mix_out8), 0);
        chk("rst_mix_valid", int'(mix_valid8), 0);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_att_sel", int'(if8.att_sel), 15);
        chk("rst_att_snd", int'(if8.att_snd_in), 0);
        chk("rst_state", int'(dbg8), int'(IDLE));
`ifdef ATT_OVERRUN_EN
        chk("rst_overrun", int'(overrun8), 0);
`endif

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst) do_reset();
            if (vecs[i].nw > 0) write_byte(vecs[i].w0);
            if (vecs[i].nw > 1) write_byte(vecs[i].w1);
            if (vecs[i].nw > 2) write_byte(vecs[i].w2);
            if (vecs[i].nw > 3) write_byte(vecs[i].w3);
            run_frame(vecs[i].snd, vecs[i].e8, vecs[i].e7, 0, 0, 8'h00, 0);
        end

        // tick while busy is dropped
        do_reset();
        write_byte(8'h90);
        run_frame(4'b0001, 8'd63, 7'd63, 2, 0, 8'h00, 0);
`ifdef ATT_OVERRUN_EN
        chk("overrun_set", int'(overrun8), 1);
`endif

        // write during RUN only reaches the next frame
        run_frame(4'b0001, 8'd63, 7'd63, 0, 2, 8'h9F, 0);
        run_frame(4'b0001, 8'd0, 7'd0, 0, 0, 8'h00, 0);

        // reset mid-frame aborts it and silences every channel
        write_byte(8'h90);
        write_byte(8'hB0);
        run_frame(4'b1111, 8'd0, 7'd0, 0, 0, 8'h00, 3);
`ifdef ATT_OVERRUN_EN
        chk("overrun_cleared", int'(overrun8), 0);
`endif
        run_frame(4'b1111, 8'd0, 7'd0, 0, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
